// File: rtl/i2c_seq_matcher.sv
// Passive I2C monitor: pulses match when a framed transaction equals PATTERN.
// Optional ACK enforcement via I2C_SEQ_ACK_CHECK_EN.
module i2c_seq_matcher #(
   parameter int                     NUM_BYTES = 4,
   parameter logic [8*NUM_BYTES-1:0] PATTERN   = 32'hA0123456
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               sda,
   input  logic                               scl,
   output logic                               match,
   output logic                               error,
   output logic                               busy,
   output logic [$clog2(NUM_BYTES+1)-1:0]     byte_cnt,
   output logic [2:0]                         state
);
   localparam int CW = $clog2(NUM_BYTES+1);
   localparam logic [CW-1:0] LAST = CW'(NUM_BYTES-1);
   localparam logic [CW-1:0] FULL = CW'(NUM_BYTES);

   typedef enum logic [2:0] {
      IDLE = 3'd0, BITS = 3'd1, ACK = 3'd2, WAIT_STOP = 3'd3, HUNT = 3'd4
   } state_t;

   state_t      cur, nxt;
   logic        sda_m, sda_s, sda_p, scl_m, scl_s, scl_p;
   logic        start, stop, rise;
   logic [7:0]  shreg, pat_byte;
   logic [3:0]  bit_cnt;
   logic        byte_ok, ack_ok, bit8, match_nxt, error_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         {sda_m, sda_s, sda_p} <= 3'b111;
         {scl_m, scl_s, scl_p} <= 3'b111;
      end else begin
         sda_m <= sda;  sda_s <= sda_m;  sda_p <= sda_s;
         scl_m <= scl;  scl_s <= scl_m;  scl_p <= scl_s;
      end
   end

   assign start = scl_s & scl_p & sda_p & ~sda_s;
   assign stop  = scl_s & scl_p & ~sda_p & sda_s;
   assign rise  = scl_s & ~scl_p;

   always_comb begin
      pat_byte = '0;
      for (int i = 0; i < NUM_BYTES; i++)
         if (byte_cnt == CW'(i)) pat_byte = PATTERN[8*(NUM_BYTES-1-i) +: 8];
   end

   // shreg is cleared at every byte start, so bit 7 is still 0 on the 8th bit
   assign byte_ok = ~shreg[7] && ({shreg[6:0], sda_s} == pat_byte);
   assign bit8    = rise && (bit_cnt == 4'd7);
`ifdef I2C_SEQ_ACK_CHECK_EN
   assign ack_ok  = ~sda_s;
`else
   assign ack_ok  = 1'b1;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur   <= IDLE;
         match <= 1'b0;
         error <= 1'b0;
      end else begin
         cur   <= nxt;
         match <= match_nxt;
         error <= error_nxt;
      end
   end

   always_comb begin
      nxt = cur;
      if (start) nxt = BITS;
      else begin
         case (cur)
            IDLE:      nxt = IDLE;
            BITS:      if (stop) nxt = IDLE;
                       else if (bit8) nxt = byte_ok ? ACK : HUNT;
            ACK:       if (stop) nxt = IDLE;
                       else if (rise) nxt = !ack_ok ? HUNT :
                                            (byte_cnt == LAST) ? WAIT_STOP : BITS;
            WAIT_STOP: if (stop) nxt = IDLE;
                       else if (rise) nxt = HUNT;
            HUNT:      if (stop) nxt = IDLE;
            default:   nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      match_nxt = 1'b0;
      error_nxt = 1'b0;
      if (!start) begin
         case (cur)
            BITS:      error_nxt = stop || (bit8 && !byte_ok);
            ACK:       error_nxt = stop || (rise && !ack_ok);
            WAIT_STOP: begin
               match_nxt = stop;
               error_nxt = rise;
            end
            default:   ;
         endcase
      end
   end

   assign busy  = (cur != IDLE);
   assign state = cur;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else if (start) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else if (nxt == IDLE && cur != IDLE) begin
         bit_cnt  <= '0;
         byte_cnt <= '0;
      end else if (cur == BITS && rise) begin
         shreg    <= {shreg[6:0], sda_s};
         bit_cnt  <= bit_cnt + 4'd1;
      end else if (cur == ACK && rise && ack_ok) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         if (byte_cnt != FULL) byte_cnt <= byte_cnt + CW'(1);
      end
   end
endmodule

// File: tb/tb_i2c_seq_matcher.sv
// Directed bench for i2c_seq_matcher: a default 4-byte instance plus a
// 1-byte (8'h5A) instance sharing the same bus.
module tb_i2c_seq_matcher;
   localparam int Q = 4;

   logic       clk = 1'b0, reset = 1'b1, sda = 1'b1, scl = 1'b1;
   logic       m0, e0, busy0, m1, e1, busy1;
   logic [2:0] bc0, st0, st1;
   logic [0:0] bc1;

   always #5 clk = ~clk;

   i2c_seq_matcher dut0 (
      .clk(clk), .reset(reset), .sda(sda), .scl(scl),
      .match(m0), .error(e0), .busy(busy0), .byte_cnt(bc0), .state(st0));

   i2c_seq_matcher #(.NUM_BYTES(1), .PATTERN(8'h5A)) dut1 (
      .clk(clk), .reset(reset), .sda(sda), .scl(scl),
      .match(m1), .error(e1), .busy(busy1), .byte_cnt(bc1), .state(st1));

   int checks = 0, failures = 0;
   int mc0 = 0, ec0 = 0, mc1 = 0, ec1 = 0, both = 0, wide = 0;
   logic pm0 = 1'b0, pe0 = 1'b0;

   always @(posedge clk) begin
      #1;
      if (m0) mc0++;
      if (e0) ec0++;
      if (m1) mc1++;
      if (e1) ec1++;
      if ((m0 && e0) || (m1 && e1)) both++;
      if ((m0 && pm0) || (e0 && pe0)) wide++;
      pm0 = m0;
      pe0 = e0;
   end

   typedef struct {
      logic [31:0] data;
      int          nb;
      logic [3:0]  nack;
      logic        extra;
      int          e_match;
      int          e_err;
      int          e_state;
      int          e_bc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   task automatic q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic bit_hi(input logic b);
      sda = b; q(); scl = 1'b1; q(); q();
   endtask

   task automatic bit_lo();
      scl = 1'b0; q();
   endtask

   task automatic i2c_start();
      sda = 1'b1; scl = 1'b1; q(); sda = 1'b0; q(); scl = 1'b0; q();
   endtask

   // Leaves scl high during the ACK bit so a STOP can follow without an extra rise
   task automatic send_byte(input logic [7:0] b, input logic ackv);
      for (int i = 7; i >= 0; i--) begin
         bit_hi(b[i]);
         bit_lo();
      end
      bit_hi(ackv);
   endtask

   task automatic stop_hi();
      sda = 1'b1; q(); q();
   endtask

   task automatic stop_full();
      scl = 1'b0; q(); sda = 1'b0; q(); scl = 1'b1; q(); sda = 1'b1; q(); q();
   endtask

   task automatic rstart();
      sda = 1'b1; q(); scl = 1'b1; q(); sda = 1'b0; q(); scl = 1'b0; q();
   endtask

   task automatic send_pattern(input logic [31:0] p);
      for (int i = 0; i < 4; i++) begin
         send_byte(p[31-8*i -: 8], 1'b0);
         if (i < 3) bit_lo();
      end
   endtask

   initial begin
      logic [31:0] pat;
      logic [7:0]  b12;
      int bm, be, bm1, be1;
      pat = 32'hA0123456;
      b12 = 8'h12;

      vecs[0] = '{32'hA0123456, 4, 4'b0000, 1'b0, 1, 0, 3, 4};
      vecs[1] = '{32'hA0123556, 4, 4'b0000, 1'b0, 0, 1, 4, 2};
`ifdef I2C_SEQ_ACK_CHECK_EN
      vecs[2] = '{32'hA0123456, 4, 4'b0010, 1'b0, 0, 1, 4, 1};
`else
      vecs[2] = '{32'hA0123456, 4, 4'b0010, 1'b0, 1, 0, 3, 4};
`endif
      vecs[3] = '{32'hA0123456, 4, 4'b0000, 1'b1, 0, 1, 4, 4};
      vecs[4] = '{32'h12345678, 4, 4'b0000, 1'b0, 0, 1, 4, 0};
      vecs[5] = '{32'hA0123400, 3, 4'b0000, 1'b0, 0, 1, 1, 3};

      // reset values, then quiet bus
      repeat (3) @(negedge clk);
      chk("rst_match", m0, 0);
      chk("rst_error", e0, 0);
      chk("rst_busy", busy0, 0);
      chk("rst_byte_cnt", bc0, 0);
      chk("rst_state", st0, 0);
      chk("rst_state_1b", st1, 0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("idle_state", st0, 0);
      chk("idle_pulses", mc0 + ec0, 0);

      // full pattern with byte_cnt stepping and exact match latency
      bm = mc0; be = ec0;
      i2c_start();
      chk("bc_step0", bc0, 0);
      for (int i = 0; i < 4; i++) begin
         send_byte(pat[31-8*i -: 8], 1'b0);
         chk($sformatf("bc_step%0d", i + 1), bc0, i + 1);
         if (i < 3) bit_lo();
      end
      sda = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      chk("lat_match_early", m0, 0);
      @(posedge clk); #1;
      chk("lat_match", m0, 1);
      chk("lat_busy", busy0, 0);
      chk("lat_state", st0, 0);
      @(posedge clk); #1;
      chk("lat_match_after", m0, 0);
      @(negedge clk); q();
      chk("lat_match_cnt", mc0 - bm, 1);
      chk("lat_err_cnt", ec0 - be, 0);

      // table-driven transactions
      for (int k = 0; k < 6; k++) begin
         bm = mc0; be = ec0;
         i2c_start();
         for (int i = 0; i < vecs[k].nb; i++) begin
            send_byte(vecs[k].data[31-8*i -: 8], vecs[k].nack[i]);
            if (i < vecs[k].nb - 1 || vecs[k].extra) bit_lo();
         end
         if (vecs[k].extra) send_byte(8'hFF, 1'b0);
         chk($sformatf("v%0d_state", k), st0, vecs[k].e_state);
         chk($sformatf("v%0d_byte_cnt", k), bc0, vecs[k].e_bc);
         stop_hi(); q();
         chk($sformatf("v%0d_match", k), mc0 - bm, vecs[k].e_match);
         chk($sformatf("v%0d_error", k), ec0 - be, vecs[k].e_err);
         chk($sformatf("v%0d_end_state", k), st0, 0);
      end

      // repeated START restarts matching
      bm = mc0; be = ec0;
      i2c_start();
      send_byte(8'hA0, 1'b0); bit_lo();
      send_byte(8'h12, 1'b0); bit_lo();
      chk("rs_bc_before", bc0, 2);
      rstart();
      chk("rs_bc_after", bc0, 0);
      chk("rs_state", st0, 1);
      send_pattern(pat);
      stop_hi(); q();
      chk("rs_match", mc0 - bm, 1);
      chk("rs_error", ec0 - be, 0);

      // STOP before the 8th bit of the first byte
      bm = mc0; be = ec0;
      i2c_start();
      bit_hi(1'b1); bit_lo(); bit_hi(1'b0); bit_lo(); bit_hi(1'b1); bit_lo();
      bit_hi(1'b0); bit_lo(); bit_hi(1'b0); bit_lo();
      stop_full(); q();
      chk("early_stop_error", ec0 - be, 1);
      chk("early_stop_match", mc0 - bm, 0);
      chk("early_stop_state", st0, 0);

      // reset in the middle of byte 2; the tail must not match
      i2c_start();
      send_byte(8'hA0, 1'b0); bit_lo();
      for (int i = 7; i >= 5; i--) begin bit_hi(b12[i]); bit_lo(); end
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid_rst_state", st0, 0);
      chk("mid_rst_bc", bc0, 0);
      chk("mid_rst_busy", busy0, 0);
      @(negedge clk);
      reset = 1'b0;
      bm = mc0; be = ec0;
      for (int i = 4; i >= 0; i--) begin bit_hi(b12[i]); bit_lo(); end
      bit_hi(1'b0); bit_lo();
      send_byte(8'h34, 1'b0); bit_lo();
      send_byte(8'h56, 1'b0);
      stop_hi(); q();
      chk("post_rst_match", mc0 - bm, 0);
      chk("post_rst_error", ec0 - be, 0);
      chk("post_rst_state", st0, 0);
      i2c_start();
      send_pattern(pat);
      stop_hi(); q();
      chk("post_rst_rematch", mc0 - bm, 1);

      // single-byte instance
      bm1 = mc1; be1 = ec1;
      i2c_start();
      send_byte(8'h5A, 1'b0);
      stop_hi(); q();
      chk("one_byte_match", mc1 - bm1, 1);
      chk("one_byte_error", ec1 - be1, 0);

      chk("pulse_overlap", both, 0);
      chk("pulse_width", wide, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/i2c_seq_matcher.md
# i2c_seq_matcher

Parametrised I2C sequence matcher. Passively monitors an I2C bus (sda/scl) against a configurable byte pattern. Oversamples both lines on the system clock, detects START/STOP/repeated START, deserialises bytes MSB-first and compares each against a compile-time pattern. Pulses `match` when a complete framed transaction equals the pattern. Sits beside bus monitor/debug logic as the reusable replacement for fixed, hard-coded waveform recognisers.

## Interface
- `NUM_BYTES`, 4, bytes in the pattern, 1..16
- `PATTERN`, 32'hA0123456, 8*NUM_BYTES bits; first transmitted byte in the top byte, bits MSB-first
- `clk` input 1 system clock, rising edge; must be ≥4× scl rate
- `reset` input 1 asynchronous, active-high; one clock, all flops async-cleared
- `sda` input 1 raw bus data, asynchronous to clk
- `scl` input 1 raw bus clock, asynchronous to clk
- `match` output 1 one-cycle pulse: full pattern received and terminated by STOP
- `error` output 1 one-cycle pulse: framing, data or ACK failure
- `busy` output 1 high whenever state != IDLE
- `byte_cnt` output $clog2(NUM_BYTES+1) bytes matched so far in current transaction
- `state` output 3 current FSM state encoding (debug)

## Operation
- Two-flop synchroniser per line (sda_s, scl_s), reset value 1; one register of previous values (sda_p, scl_p), reset value 1.
- Events (combinational, from synced/prev): START = scl_s & scl_p & sda_p & !sda_s; STOP = scl_s & scl_p & !sda_p & sda_s; RISE = scl_s & !scl_p. At most one is true per cycle by construction.
- Internal: 8-bit shift register, 4-bit bit counter.
- States: IDLE=0, BITS=1, ACK=2, WAIT_STOP=3, HUNT=4.
- START in any state: clear bit/byte counters, go BITS, no pulse (repeated START restarts matching).
- IDLE: ignore RISE and STOP.
- BITS: RISE shifts sda_s in, bit_cnt+1. On 8th bit compare {shreg[6:0],sda_s} with pattern byte byte_cnt; equal → ACK; unequal → error, HUNT. STOP → error, IDLE.
- ACK: RISE samples ACK bit (see Configuration); accepted → byte_cnt+1, bit_cnt=0; if byte_cnt+1 == NUM_BYTES → WAIT_STOP else BITS. STOP → error, IDLE.
- WAIT_STOP: STOP → match, IDLE. RISE (extra data) → error, HUNT.
- HUNT: STOP → IDLE; RISE ignored; no further error pulses.
- Undefined state encodings recover to IDLE next cycle.
- byte_cnt saturates at NUM_BYTES; cleared on IDLE entry and on START.

## Timing
- Reset values: match=0, error=0, busy=0, byte_cnt=0, state=IDLE, shreg=0, bit_cnt=0.
- Latency: a pin change is acted on at the 3rd rising clk edge after it is setup (2 sync + 1 prev); match/error go high at that edge and last exactly one cycle.
- match and error never high in the same cycle.
- Reset asserted mid-transaction: immediate return to reset values; after release, the block stays in IDLE until a fresh START (partial transaction never matches).
- Inputs held constant: no events, no state change.

## Configuration
- `I2C_SEQ_ACK_CHECK_EN` defined: in ACK state the sampled bit must be 0; a 1 (NACK) → error pulse, HUNT.
- Undefined: ACK bit value ignored, always accepted; NACKed transactions can still match.

## Test plan
- Default params: START, bytes A0,12,34,56 each ACKed (sda=0 on 9th clock), STOP → single match pulse 3 clks after STOP edge, error never high, byte_cnt steps 0→4, busy falls with match.
- Same but byte 3 = 35 → error pulse at 8th RISE of byte 3, state HUNT, no match; STOP → IDLE.
- NACK on byte 2: with `I2C_SEQ_ACK_CHECK_EN` → error, no match; without it → match.
- START, A0,12, repeated START, A0,12,34,56, STOP → byte_cnt resets to 0 at repeated START, exactly one match, no error.
- Full pattern then 9 extra scl pulses before STOP → error at first extra RISE, no match; STOP before 8th bit of byte 1 → error, IDLE.
- Assert reset mid byte 2 for one clk, then resend full pattern → matches only after the new START; NUM_BYTES=1, PATTERN=8'h5A: START,5A,ACK,STOP → match.
